// File: rtl/axil_if.sv
// AXI4-Lite bus bundle between an initiator and the register slave.
// Signal names follow the AXI S_AXI_* convention.
interface axil_if #(
    parameter int ADDR_WIDTH = 6
);
    logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
    logic [2:0]            S_AXI_AWPROT;
    logic                  S_AXI_AWVALID;
    logic                  S_AXI_AWREADY;
    logic [31:0]           S_AXI_WDATA;
    logic [3:0]            S_AXI_WSTRB;
    logic                  S_AXI_WVALID;
    logic                  S_AXI_WREADY;
    logic [1:0]            S_AXI_BRESP;
    logic                  S_AXI_BVALID;
    logic                  S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
    logic [2:0]            S_AXI_ARPROT;
    logic                  S_AXI_ARVALID;
    logic                  S_AXI_ARREADY;
    logic [31:0]           S_AXI_RDATA;
    logic [1:0]            S_AXI_RRESP;
    logic                  S_AXI_RVALID;
    logic                  S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register bank: independent AW/W capture, byte strobes,
// SLVERR on out-of-range index, per-register write pulses.
module axil_reg_slave #(
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    axil_if.slave                    s_axi,
    output logic [NUM_REGS*32-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      reg_wr_pulse
);
    localparam int IW = ADDR_WIDTH - 2;
    localparam int SW = DATA_WIDTH / 8;

    localparam logic [1:0] W_IDLE    = 2'd0;
    localparam logic [1:0] W_HAVE_AW = 2'd1;
    localparam logic [1:0] W_HAVE_W  = 2'd2;
    localparam logic [1:0] W_RESP    = 2'd3;
    localparam logic [0:0] R_IDLE    = 1'b0;
    localparam logic [0:0] R_RESP    = 1'b1;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic [1:0]            wstate_q, wstate_d;
    logic [0:0]            rstate_q, rstate_d;
    logic [IW-1:0]         awidx_q, awidx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         wstrb_q, wstrb_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [NUM_REGS-1:0]   pulse_q, pulse_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  aw_held, w_held, bvalid;
    logic                  awready, wready, arready;
    logic                  aw_hs, w_hs, commit;
    logic [IW-1:0]         c_idx, ar_idx;
    logic [DATA_WIDTH-1:0] c_data, r_sel;
    logic [SW-1:0]         c_strb;
    logic                  c_hit, ar_hit;

    function automatic logic in_range(input logic [IW-1:0] idx);
        return 32'(idx) < 32'(NUM_REGS);
    endfunction

    assign aw_held = (wstate_q == W_HAVE_AW);
    assign w_held  = (wstate_q == W_HAVE_W);
    assign bvalid  = (wstate_q == W_RESP);

    // Readies are forced low for as long as reset is asserted.
    assign awready = !ARESET && !aw_held && !bvalid;
    assign wready  = !ARESET && !w_held && !bvalid;
    assign arready = !ARESET && (rstate_q == R_IDLE);

    assign aw_hs  = s_axi.S_AXI_AWVALID && awready;
    assign w_hs   = s_axi.S_AXI_WVALID && wready;
    assign commit = (aw_held || aw_hs) && (w_held || w_hs);

    assign c_idx  = aw_held ? awidx_q : s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:2];
    assign c_data = w_held ? wdata_q : s_axi.S_AXI_WDATA;
    assign c_strb = w_held ? wstrb_q : s_axi.S_AXI_WSTRB;
    assign c_hit  = in_range(c_idx);

    assign ar_idx = s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign ar_hit = in_range(ar_idx);

    always_comb begin
        r_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(ar_idx) == 32'(i)) r_sel = regs_q[i];
        end
    end

    always_comb begin
        wstate_d = wstate_q;
        awidx_d  = awidx_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bresp_d  = bresp_q;
        if (commit) begin
            wstate_d = W_RESP;
            bresp_d  = c_hit ? OKAY : SLVERR;
        end else if (bvalid) begin
            if (s_axi.S_AXI_BREADY) wstate_d = W_IDLE;
        end else if (aw_hs) begin
            wstate_d = W_HAVE_AW;
            awidx_d  = c_idx;
        end else if (w_hs) begin
            wstate_d = W_HAVE_W;
            wdata_d  = s_axi.S_AXI_WDATA;
            wstrb_d  = s_axi.S_AXI_WSTRB;
        end
    end

    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (commit && c_hit && 32'(c_idx) == 32'(i)) begin
                pulse_d[i] = 1'b1;
                for (int b = 0; b < SW; b++) begin
                    if (c_strb[b]) regs_d[i][8*b+:8] = c_data[8*b+:8];
                end
            end
        end
    end

    // Read samples regs_q, so a same-edge write is not yet visible.
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        unique case (rstate_q)
            R_IDLE: begin
                if (s_axi.S_AXI_ARVALID && arready) begin
                    rstate_d = R_RESP;
                    rdata_d  = r_sel;
                    rresp_d  = ar_hit ? OKAY : SLVERR;
                end
            end
            R_RESP: begin
                if (s_axi.S_AXI_RREADY) rstate_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
            awidx_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= OKAY;
            rdata_q  <= '0;
            rresp_q  <= OKAY;
            pulse_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            awidx_q  <= awidx_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            bresp_q  <= bresp_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            pulse_q  <= pulse_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_BVALID  = bvalid;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_RVALID  = (rstate_q == R_RESP);
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign reg_wr_pulse        = pulse_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[32*g+:32] = regs_q[g];
    end

    logic unused_ok;
    assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
endmodule
